fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one requester at a time for up to BURST
// beats into a FIFO, stalling while the FIFO is full or would overflow.
`timescale 1ns/1ps
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int BURST = 4
) (
  input  logic                 wr_clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 full,
  input  logic [3:0]           fifo_counter,
  output logic                 wr_en,
  output logic [DW-1:0]        wdata,
  output logic [1:0]           grant_id,
  output logic                 busy,
  output logic [15:0]          wr_count
);

  localparam int BW = $clog2(BURST + 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_rr_ptr;
  logic [BW-1:0]   r_beat_cnt;
  logic [1:0]      r_grant_id;
  logic            r_wr_en;
  logic [DW-1:0]   r_wdata;
  logic [15:0]     r_wr_count;

  logic [4:0]      w_fill;
  logic            w_space_ok;
  logic            w_accept;
  logic            w_last_beat;
  logic            w_exit;
  logic            w_found;
  logic            w_start;
  logic [1:0]      w_sel;

  // The write already in flight counts against capacity, so a FIFO at
  // DEPTH-1 cannot take a second beat before its counter catches up.
  assign w_fill      = {1'b0, fifo_counter} + {4'b0, r_wr_en};
  assign w_space_ok  = (w_fill < 5'(DEPTH)) && !full;
  assign w_accept    = (r_state == ST_BURST) && !rst && req_valid[r_grant_id] && w_space_ok;
  assign w_last_beat = (r_beat_cnt == BW'(BURST - 1));
  assign w_exit      = (r_state == ST_BURST) &&
                       (!req_valid[r_grant_id] || (w_accept && w_last_beat));
  assign w_start     = (r_state == ST_IDLE) && w_found && !full;

  // Descending scan so the closest valid requester at/after rr_ptr wins last.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_rr_ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(r_rr_ptr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_sel   = 2'((int'(r_rr_ptr) + k) % NREQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && (r_state == ST_BURST) && w_space_ok) begin
      req_ready[r_grant_id] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_state_nxt = ST_BURST;
      ST_BURST: if (w_exit)  w_state_nxt = ST_IDLE;
      default:               w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered write port: accepted beat appears on wr_en/wdata one edge later.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
      r_grant_id <= '0;
      r_wr_en    <= 1'b0;
      r_wdata    <= '0;
      r_wr_count <= '0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_wdata    <= req_data[r_grant_id*DW +: DW];
        r_wr_count <= r_wr_count + 16'd1;
        r_beat_cnt <= r_beat_cnt + BW'(1);
      end
      if (w_start) begin
        r_grant_id <= w_sel;
        r_beat_cnt <= '0;
      end
      if (w_exit) begin
        r_rr_ptr <= (r_grant_id == 2'(NREQ - 1)) ? 2'd0 : r_grant_id + 2'd1;
      end
    end
  end

  assign wr_en    = r_wr_en;
  assign wdata    = r_wdata;
  assign grant_id = r_grant_id;
  assign busy     = (r_state == ST_BURST);
  assign wr_count = r_wr_count;

endmodule
